product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/prod_acc_pkg.sv | 19 +
 rtl/product_accumulator_if.sv | 27 ++
 rtl/result_fifo2.sv | 74 +++++++
 rtl/product_accumulator.sv | 96 +++++++++
 tb/tb_product_accumulator.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prod_acc_pkg.sv
// Shared defaults, FSM state encoding and result record for the product accumulator.
// No logic; widths here match the default parameterisation of the top.
package prod_acc_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] sum;
    logic [CNT_W_DEF-1:0] count;
    logic                 ovf;
  } result_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, block results out; master is the producer/consumer side.
// Input has no ready; results use valid/ready.
interface product_accumulator_if import prod_acc_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             in_valid;
  logic [31:0]      in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/result_fifo2.sv
// Two-entry FIFO with a registered head; push-to-head latency 1 cycle.
// A push while full is accepted only if a pop happens in the same cycle, otherwise ignored.
module result_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_dat_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop;
  logic         push;

  assign pop  = pop_i && (cnt_q != 2'd0);
  assign push = push_i && ((cnt_q != 2'd2) || pop);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = push_dat_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_dat_i;
        end else if (push) begin
          tail_d = push_dat_i;
          cnt_d  = 2'd2;
        end else if (pop) begin
          head_d = '0;
          cnt_d  = 2'd0;
        end
      end
      default: begin
        // Full: the tail moves up on a pop, and a same-cycle push refills the tail.
        if (pop) begin
          head_d = tail_q;
          tail_d = push ? push_dat_i : '0;
          cnt_d  = push ? 2'd2 : 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);
  assign head_dat_o = head_q;

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of 32-bit products with saturation and queues {sum, count, ovf} per block; result 1 cycle after in_last.
// Input is never stalled; a block completing into a full result FIFO is dropped and flagged in drop_err.
module product_accumulator import prod_acc_pkg::*; #(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus,
  output logic                  drop_err
);

  localparam int RES_W = ACC_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             drop_q, drop_d;
  logic [ACC_W:0]   sum_ext;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RES_W-1:0] head;
  logic [RES_W-1:0] res;

  assign pop = bus.out_ready && !fifo_empty;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    sum_ext = '0;
    if (bus.in_valid) begin
      if (state_q == IDLE) begin
        acc_d = ACC_W'(bus.in_product);
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        sum_ext = {1'b0, acc_q} + (ACC_W+1)'(bus.in_product);
        if (sum_ext[ACC_W]) begin
          acc_d = '1;
          ovf_d = 1'b1;
        end else begin
          acc_d = sum_ext[ACC_W-1:0];
        end
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      push    = bus.in_last;
      state_d = bus.in_last ? IDLE : ACCUM;
    end
    drop_d = drop_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // The pushed record carries the final beat's contribution (next-state values).
  result_fifo2 #(.W(RES_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i ({acc_d, cnt_d, ovf_d}),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_dat_o (head)
  );

  assign res           = fifo_empty ? '0 : head;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_sum   = res[RES_W-1 -: ACC_W];
  assign bus.out_count = res[CNT_W:1];
  assign bus.out_ovf   = res[0];
  assign drop_err      = drop_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: scoreboard queue models the 2-entry result FIFO and block sums.
module tb_product_accumulator;
  import prod_acc_pkg::*;

  localparam int ACC_W = ACC_W_DEF;
  localparam int CNT_W = CNT_W_DEF;

  logic clk = 1'b0;
  logic rst;
  logic drop_err;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus();

  product_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .drop_err (drop_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  result_t        exp_q[$];
  bit             m_in_blk;
  bit             m_ovf;
  bit             m_drop;
  logic [ACC_W:0] m_acc;
  int             m_cnt;

  bit      got_v, exp_v, got_drop, exp_drop;
  result_t got_r, exp_r;

  task automatic model_reset();
    exp_q.delete();
    m_in_blk = 1'b0;
    m_ovf    = 1'b0;
    m_drop   = 1'b0;
    m_acc    = '0;
    m_cnt    = 0;
  endtask

  task automatic drive_idle();
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  // Drive one cycle of stimulus, sample the DUT, and advance the reference model past the next edge.
  task automatic step(input bit v, input logic [31:0] p, input bit l, input bit r);
    result_t res;
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_product = p;
    bus.in_last    = l;
    bus.out_ready  = r;
    got_v    = bus.out_valid;
    got_r    = {bus.out_sum, bus.out_count, bus.out_ovf};
    got_drop = drop_err;
    exp_v    = (exp_q.size() != 0);
    exp_r    = '0;
    if (exp_v) exp_r = exp_q[0];
    exp_drop = m_drop;
    if (exp_v && r) void'(exp_q.pop_front());
    if (v) begin
      if (!m_in_blk) begin
        m_acc = (ACC_W+1)'(p);
        m_cnt = 1;
        m_ovf = 1'b0;
      end else begin
        m_acc = m_acc + (ACC_W+1)'(p);
        if (m_acc[ACC_W]) begin
          m_acc = {1'b0, {ACC_W{1'b1}}};
          m_ovf = 1'b1;
        end
        if (m_cnt < (2**CNT_W - 1)) m_cnt++;
      end
      m_in_blk = !l;
      if (l) begin
        res.sum   = m_acc[ACC_W-1:0];
        res.count = m_cnt[CNT_W-1:0];
        res.ovf   = m_ovf;
        if (exp_q.size() < 2) exp_q.push_back(res);
        else m_drop = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_idle();
    model_reset();
    #3;
    n_cmp++;
    if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, drop_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%0b sum=%h cnt=%0d ovf=%0b drop=%0b, want all zero",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, drop_err);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, drop_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_held: got v=%0b sum=%h cnt=%0d ovf=%0b drop=%0b, want all zero",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, drop_err);
    end
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_single();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       step(1'b1, 32'hFFFE_0001, 1'b1, 1'b0);
        1:       step(1'b0, 32'h0, 1'b0, 1'b0);
        default: step(1'b0, 32'h0, 1'b0, 1'b1);
      endcase
      n_cmp++;
      if (got_v !== exp_v || got_r !== exp_r || got_drop !== exp_drop) begin
        n_bad++;
        $display("FAIL single cyc%0d: got v=%0b %h/%0d/%0b drop=%0b, want v=%0b %h/%0d/%0b drop=%0b",
                 i, got_v, got_r.sum, got_r.count, got_r.ovf, got_drop,
                 exp_v, exp_r.sum, exp_r.count, exp_r.ovf, exp_drop);
      end
      if (i == 1) begin
        n_cmp++;
        if (got_v !== 1'b1 || got_r.sum !== 40'hFF_FE00_01 * 1 + 40'h0 || got_r.count !== 16'd1 || got_r.ovf !== 1'b0) begin
          n_bad++;
          $display("FAIL single_result: got v=%0b sum=%h cnt=%0d ovf=%0b, want v=1 sum=00fffe0001 cnt=1 ovf=0",
                   got_v, got_r.sum, got_r.count, got_r.ovf);
        end
      end
    end
  endtask

  task automatic test_three_beat();
    logic [31:0] vals [7] = '{100, 200, 0, 300, 0, 0, 0};
    bit          vlds [7] = '{1, 1, 0, 1, 0, 0, 0};
    bit          lsts [7] = '{0, 0, 1, 1, 0, 0, 0};
    int          npop = 0;
    result_t     popped = '0;
    for (int i = 0; i < 7; i++) begin
      step(vlds[i], vals[i], lsts[i], 1'b1);
      n_cmp++;
      if (got_v !== exp_v || got_r !== exp_r || got_drop !== exp_drop) begin
        n_bad++;
        $display("FAIL three_beat cyc%0d: got v=%0b %h/%0d/%0b drop=%0b, want v=%0b %h/%0d/%0b drop=%0b",
                 i, got_v, got_r.sum, got_r.count, got_r.ovf, got_drop,
                 exp_v, exp_r.sum, exp_r.count, exp_r.ovf, exp_drop);
      end
      if (got_v) begin
        npop++;
        popped = got_r;
      end
    end
    n_cmp++;
    if (npop !== 1 || popped.sum !== 40'd600 || popped.count !== 16'd3 || got_v !== 1'b0) begin
      n_bad++;
      $display("FAIL three_beat_result: got pops=%0d sum=%0d cnt=%0d final_v=%0b, want pops=1 sum=600 cnt=3 final_v=0",
               npop, popped.sum, popped.count, got_v);
    end
  endtask

  task automatic test_overflow();
    result_t pops[$];
    for (int i = 0; i < 306; i++) begin
      if (i < 300)       step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
      else if (i == 300) step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      else if (i == 301) step(1'b1, 32'd5, 1'b1, 1'b1);
      else               step(1'b0, 32'd0, 1'b0, 1'b1);
      n_cmp++;
      if (got_v !== exp_v || got_r !== exp_r || got_drop !== exp_drop) begin
        n_bad++;
        $display("FAIL overflow cyc%0d: got v=%0b %h/%0d/%0b drop=%0b, want v=%0b %h/%0d/%0b drop=%0b",
                 i, got_v, got_r.sum, got_r.count, got_r.ovf, got_drop,
                 exp_v, exp_r.sum, exp_r.count, exp_r.ovf, exp_drop);
      end
      if (got_v) pops.push_back(got_r);
    end
    n_cmp++;
    if (pops.size() != 2) begin
      n_bad++;
      $display("FAIL overflow_pops: got %0d results, want 2", pops.size());
    end else if (pops[0] !== {40'hFF_FFFF_FFFF, 16'd301, 1'b1} || pops[1] !== {40'd5, 16'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL overflow_results: got %h/%0d/%0b then %h/%0d/%0b, want ffffffffff/301/1 then 0000000005/1/0",
               pops[0].sum, pops[0].count, pops[0].ovf, pops[1].sum, pops[1].count, pops[1].ovf);
    end
  endtask

  task automatic test_backpressure();
    result_t pops[$];
    for (int i = 0; i < 10; i++) begin
      if (i < 3)      step(1'b1, 32'(i + 1), 1'b1, 1'b0);
      else if (i < 5) step(1'b0, 32'd0, 1'b0, 1'b0);
      else            step(1'b0, 32'd0, 1'b0, 1'b1);
      n_cmp++;
      if (got_v !== exp_v || got_r !== exp_r || got_drop !== exp_drop) begin
        n_bad++;
        $display("FAIL backpressure cyc%0d: got v=%0b %h/%0d/%0b drop=%0b, want v=%0b %h/%0d/%0b drop=%0b",
                 i, got_v, got_r.sum, got_r.count, got_r.ovf, got_drop,
                 exp_v, exp_r.sum, exp_r.count, exp_r.ovf, exp_drop);
      end
      if (got_v && i >= 5) pops.push_back(got_r);
    end
    n_cmp++;
    if (drop_err !== 1'b1 || pops.size() != 2) begin
      n_bad++;
      $display("FAIL backpressure_drop: got drop=%0b pops=%0d, want drop=1 pops=2", drop_err, pops.size());
    end else if (pops[0].sum !== 40'd1 || pops[1].sum !== 40'd2) begin
      n_bad++;
      $display("FAIL backpressure_order: got %0d then %0d, want 1 then 2", pops[0].sum, pops[1].sum);
    end
  endtask

  task automatic test_full_push_pop();
    result_t pops[$];
    rst = 1'b0;
    drive_idle();
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 2)       step(1'b1, 32'(10 * (i + 1)), 1'b1, 1'b0);
      else if (i == 2) step(1'b1, 32'd30, 1'b1, 1'b1);
      else             step(1'b0, 32'd0, 1'b0, 1'b1);
      n_cmp++;
      if (got_v !== exp_v || got_r !== exp_r || got_drop !== exp_drop) begin
        n_bad++;
        $display("FAIL full_push_pop cyc%0d: got v=%0b %h/%0d/%0b drop=%0b, want v=%0b %h/%0d/%0b drop=%0b",
                 i, got_v, got_r.sum, got_r.count, got_r.ovf, got_drop,
                 exp_v, exp_r.sum, exp_r.count, exp_r.ovf, exp_drop);
      end
      if (got_v && i >= 2) pops.push_back(got_r);
    end
    n_cmp++;
    if (drop_err !== 1'b0 || pops.size() != 3) begin
      n_bad++;
      $display("FAIL full_push_pop_drop: got drop=%0b pops=%0d, want drop=0 pops=3", drop_err, pops.size());
    end else if (pops[0].sum !== 40'd10 || pops[1].sum !== 40'd20 || pops[2].sum !== 40'd30) begin
      n_bad++;
      $display("FAIL full_push_pop_order: got %0d,%0d,%0d, want 10,20,30", pops[0].sum, pops[1].sum, pops[2].sum);
    end
  endtask

  task automatic test_mid_reset();
    result_t pops[$];
    step(1'b1, 32'd8, 1'b1, 1'b0);
    step(1'b1, 32'd7, 1'b0, 1'b0);
    step(1'b1, 32'd9, 1'b0, 1'b0);
    n_cmp++;
    if (got_v !== exp_v || got_r !== exp_r) begin
      n_bad++;
      $display("FAIL mid_reset_pre: got v=%0b sum=%0d, want v=%0b sum=%0d", got_v, got_r.sum, exp_v, exp_r.sum);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    drive_idle();
    model_reset();
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, drop_err} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got v=%0b sum=%h cnt=%0d ovf=%0b drop=%0b, want all zero",
               bus.out_valid, bus.out_sum, bus.out_count, bus.out_ovf, drop_err);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(1'b1, 32'd4, 1'b1, 1'b1);
      else        step(1'b0, 32'd0, 1'b0, 1'b1);
      n_cmp++;
      if (got_v !== exp_v || got_r !== exp_r || got_drop !== exp_drop) begin
        n_bad++;
        $display("FAIL mid_reset cyc%0d: got v=%0b %h/%0d/%0b drop=%0b, want v=%0b %h/%0d/%0b drop=%0b",
                 i, got_v, got_r.sum, got_r.count, got_r.ovf, got_drop,
                 exp_v, exp_r.sum, exp_r.count, exp_r.ovf, exp_drop);
      end
      if (got_v) pops.push_back(got_r);
    end
    n_cmp++;
    if (pops.size() != 1) begin
      n_bad++;
      $display("FAIL mid_reset_fresh: got %0d results, want 1", pops.size());
    end else if (pops[0] !== {40'd4, 16'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL mid_reset_fresh: got %0d/%0d/%0b, want 4/1/0", pops[0].sum, pops[0].count, pops[0].ovf);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three_beat();
    test_overflow();
    test_backpressure();
    test_full_push_pop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
